multi_tick_divider: RTL and testbench
=====================================

// Module: multi_tick_divider
// PURPOSE
//  Parametrised multi-channel clock-enable generator; successor to the single-channel score divider.
//  Each channel turns clk into a 1-cycle tick strobe and a 50% square wave (slow_clk), with a
//  per-channel divide value reloadable at runtime over a valid/ready port. Sits beside the game FSM:
//  separate channels pace score update, mole spawn and display refresh, and the FSM speeds up
//  mole timing as the level rises.
// PARAMETERS
//  NUM_CH       4        number of independent channels (>=1)
//  CNT_W        32       counter / divide-value width
//  DEFAULT_DIV  9999900  divide value loaded into every channel at reset
// PORTS
//  clk         in   1                 system clock
//  reset       in   1                 asynchronous, active-high reset
//  ch_en       in   NUM_CH            per-channel run enable (0 = paused)
//  cfg_valid   in   1                 divide-value update request
//  cfg_ready   out  1                 update accepted this cycle when cfg_valid & cfg_ready
//  cfg_ch      in   max(1,clog2(NUM_CH))  target channel of update
//  cfg_div     in   CNT_W             new divide value D
//  tick        out  NUM_CH            1-cycle strobe per channel, period D+1 clk
//  slow_clk    out  NUM_CH            square wave per channel, period 2*(D+1) clk
// BEHAVIOUR
//  - State per channel: cnt[CNT_W], div_act[CNT_W], div_pend[CNT_W], pend (1 bit).
//  - Reset (async): cnt=0, div_act=DEFAULT_DIV, pend=0, tick=0, slow_clk=0. Pending updates are
//    discarded; an assertion mid-operation takes effect immediately, with no wait for clk.
//  - ch_en[i]=1, cnt>=div_act (wrap): cnt<=0, tick[i]<=1, slow_clk[i]<=~slow_clk[i];
//    if pend: div_act<=div_pend, pend<=0. Else: cnt<=cnt+1, tick[i]<=0.
//  - ch_en[i]=0: cnt, slow_clk, div_act hold; tick[i]<=0. Re-enable resumes mid-count, with no restart.
//  - tick and slow_clk are registered and update on the same edge that returns cnt to 0.
//    Enable to first tick = div_act-cnt+1 cycles.
//  - D=0: tick high every cycle, slow_clk toggles every cycle. D=2^CNT_W-1: no overflow, because
//    the compare is >=.
//  - cfg_ready = ~pend[cfg_ch] (combinational). For cfg_ch >= NUM_CH: cfg_ready=1, transfer dropped.
//  - On transfer to channel c:
//      ch_en[c]=0 -> div_act<=cfg_div, cnt<=0 (immediate).
//      ch_en[c]=1 -> div_pend<=cfg_div, pend<=1; applied at the next wrap (glitch-free period change).
//  - Transfer in the same cycle as a wrap on channel c: the wrap uses the old div_act; the new value
//    goes pending and applies at the following wrap.
//  - Channels are fully independent; only the cfg port is shared (one update per cycle).
// CONFIGURATION
//  MULTI_TICK_SYNC_EN defined:
//    - Adds input `sync` (1 bit). sync=1: every channel cnt<=0, tick<=0, slow_clk<=0, and any pending
//      div is applied to div_act (pend<=0).
//    - cfg_ready is forced 0 while sync=1.
//    - sync has priority over wrap and enable. Used to phase-align all channels at game start.
//  Not defined: no sync port; logic absent; behaviour otherwise identical.
// TESTING  (NUM_CH=2, CNT_W=8, DEFAULT_DIV=3 unless noted)
//  1. reset, ch_en=2'b01 -> tick[0] every 4 cycles, slow_clk[0] period 8; ch1 outputs stay 0.
//  2. ch0 running, cfg ch0 D=1 mid-count -> cfg_ready drops to 0; old period finishes; then period 2;
//     cfg_ready returns to 1 after the wrap.
//  3. ch1 disabled, cfg ch1 D=0, then enable -> tick[1] high every cycle from the 1st enabled edge.
//  4. ch0 paused at cnt=2 for 5 cycles -> no tick and slow_clk frozen; after resume, tick after 2 cycles.
//  5. reset asserted between clk edges mid-count with a pending update -> all outputs 0 immediately;
//     DEFAULT_DIV restored and the pending value lost.
//  6. MULTI_TICK_SYNC_EN, channels out of phase, sync pulse -> both cnt=0 and slow_clk=0;
//     subsequent ticks coincide when the D values are equal.

Source files
------------

// File: rtl/multi_tick_divider.sv
// multi_tick_divider: per-channel tick strobe / square-wave divider with runtime-reloadable divide; MULTI_TICK_SYNC_EN adds a sync input
module multi_tick_divider #(
   parameter int NUM_CH = 4,
   parameter int CNT_W = 32,
   parameter int DEFAULT_DIV = 9999900,
   localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
`ifdef MULTI_TICK_SYNC_EN
   input  logic              sync,
`endif
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] slow_clk
);
   logic sync_i;
   logic rdy;
   logic [NUM_CH-1:0] pend;
`ifdef MULTI_TICK_SYNC_EN
   assign sync_i = sync;
`else
   assign sync_i = 1'b0;
`endif
   always_comb begin
      rdy = 1'b1;
      for (int i = 0; i < NUM_CH; i++)
         if (cfg_ch == CH_W'(i)) rdy = ~pend[i];
   end
   assign cfg_ready = rdy & ~sync_i;
   for (genvar g = 0; g < NUM_CH; g++) begin : ch
      logic [CNT_W-1:0] cnt, div_act, div_pend;
      logic tick_r, slow_r, pend_r, wrap, xfer;
      assign wrap = cnt >= div_act;
      assign xfer = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));
      assign tick[g] = tick_r;
      assign slow_clk[g] = slow_r;
      assign pend[g] = pend_r;
      always_ff @(posedge clk or posedge reset)
         if (reset) begin
            cnt <= '0;
            div_act <= CNT_W'(DEFAULT_DIV);
            div_pend <= '0;
            pend_r <= 1'b0;
            tick_r <= 1'b0;
            slow_r <= 1'b0;
         end else if (sync_i) begin
            cnt <= '0;
            tick_r <= 1'b0;
            slow_r <= 1'b0;
            if (pend_r) div_act <= div_pend;
            pend_r <= 1'b0;
         end else begin
            tick_r <= ch_en[g] & wrap;
            if (ch_en[g]) begin
               if (wrap) begin
                  cnt <= '0;
                  slow_r <= ~slow_r;
                  if (pend_r) begin
                     div_act <= div_pend;
                     pend_r <= 1'b0;
                  end
               end else
                  cnt <= cnt + 1'b1;
            end
            // running channels defer the new divide to the next wrap so the period never glitches
            if (xfer) begin
               if (ch_en[g]) begin
                  div_pend <= cfg_div;
                  pend_r <= 1'b1;
               end else begin
                  div_act <= cfg_div;
                  cnt <= '0;
               end
            end
         end
   end
endmodule

// File: tb/tb_multi_tick_divider.sv
// tb_multi_tick_divider: randomized and directed checks of multi_tick_divider against a behavioural model
module tb_multi_tick_divider;
   logic clk = 1'b0, reset = 1'b1;
   logic [1:0] ch_en = '0;
   logic cfg_valid = 1'b0, cfg_ch = 1'b0;
   logic [7:0] cfg_div = '0;
   logic cfg_ready;
   logic [1:0] tick, slow_clk;
`ifdef MULTI_TICK_SYNC_EN
   logic sync = 1'b0;
`endif
   int errors = 0, checks = 0;
   int m_cnt[2], m_div[2], m_pdiv[2];
   bit m_pend[2], m_tick[2], m_slow[2];

   always #5 clk = ~clk;

   multi_tick_divider #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(3)) dut (
      .clk(clk),
      .reset(reset),
`ifdef MULTI_TICK_SYNC_EN
      .sync(sync),
`endif
      .ch_en(ch_en),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch),
      .cfg_div(cfg_div),
      .tick(tick),
      .slow_clk(slow_clk)
   );

   task automatic m_reset();
      for (int c = 0; c < 2; c++) begin
         m_cnt[c] = 0; m_div[c] = 3; m_pdiv[c] = 0;
         m_pend[c] = 0; m_tick[c] = 0; m_slow[c] = 0;
      end
   endtask

   function automatic logic [1:0] e_tick();
      return {m_tick[1], m_tick[0]};
   endfunction

   function automatic logic [1:0] e_slow();
      return {m_slow[1], m_slow[0]};
   endfunction

   function automatic logic e_rdy();
      bit s = 0;
`ifdef MULTI_TICK_SYNC_EN
      s = sync;
`endif
      return !m_pend[cfg_ch] && !s;
   endfunction

   // one clock edge: the model follows the rules for each channel, outputs settle 1 time unit later
   task automatic step();
      bit xfer, s;
      s = 0;
`ifdef MULTI_TICK_SYNC_EN
      s = sync;
`endif
      xfer = cfg_valid && e_rdy();
      @(posedge clk);
      for (int c = 0; c < 2; c++) begin
         if (s) begin
            m_cnt[c] = 0; m_tick[c] = 0; m_slow[c] = 0;
            if (m_pend[c]) m_div[c] = m_pdiv[c];
            m_pend[c] = 0;
            continue;
         end
         m_tick[c] = ch_en[c] && m_cnt[c] >= m_div[c];
         if (ch_en[c]) begin
            if (m_cnt[c] >= m_div[c]) begin
               m_cnt[c] = 0;
               m_slow[c] = !m_slow[c];
               if (m_pend[c]) begin
                  m_div[c] = m_pdiv[c];
                  m_pend[c] = 0;
               end
            end else
               m_cnt[c]++;
         end
         if (xfer && int'(cfg_ch) == c) begin
            if (ch_en[c]) begin
               m_pdiv[c] = int'(cfg_div);
               m_pend[c] = 1;
            end else begin
               m_div[c] = int'(cfg_div);
               m_cnt[c] = 0;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; ch_en = '0; cfg_valid = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (tick !== 2'b00 || slow_clk !== 2'b00 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset tick=%b slow=%b rdy=%b want 00 00 1", tick, slow_clk, cfg_ready);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int nt = 0;
      ch_en = 2'b01;
      for (int i = 0; i < 24; i++) begin
         step();
         nt += int'(tick[0]);
         checks++;
         if (tick !== e_tick() || slow_clk !== e_slow()) begin
            errors++;
            $display("FAIL basic cyc%0d tick=%b slow=%b want %b %b", i, tick, slow_clk, e_tick(), e_slow());
         end
      end
      checks++;
      if (nt != 6) begin
         errors++;
         $display("FAIL basic_count ticks=%0d want 6", nt);
      end
   endtask

   task automatic test_reload();
      step();
      cfg_ch = 1'b0; cfg_div = 8'd1;
      #1;
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reload_ready_pre rdy=%b want 1", cfg_ready);
      end
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL reload_ready_pend rdy=%b want 0", cfg_ready);
      end
      for (int i = 0; i < 12; i++) begin
         step();
         checks++;
         if (tick !== e_tick() || slow_clk !== e_slow() || cfg_ready !== e_rdy()) begin
            errors++;
            $display("FAIL reload cyc%0d tick=%b slow=%b rdy=%b want %b %b %b", i, tick, slow_clk, cfg_ready, e_tick(), e_slow(), e_rdy());
         end
      end
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reload_ready_post rdy=%b want 1", cfg_ready);
      end
   endtask

   task automatic test_disabled_load();
      cfg_ch = 1'b1; cfg_div = 8'd0; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      ch_en = 2'b11;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (tick[1] !== 1'b1 || tick !== e_tick() || slow_clk !== e_slow()) begin
            errors++;
            $display("FAIL d0_tick cyc%0d tick=%b slow=%b want %b %b", i, tick, slow_clk, e_tick(), e_slow());
         end
      end
   endtask

   task automatic test_pause();
      logic s0;
      ch_en = 2'b10; cfg_ch = 1'b0; cfg_div = 8'd3; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      ch_en = 2'b11;
      for (int i = 0; i < 20 && m_cnt[0] != 2; i++) step();
      s0 = slow_clk[0];
      ch_en = 2'b10;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (tick[0] !== 1'b0 || slow_clk[0] !== s0 || tick !== e_tick() || slow_clk !== e_slow()) begin
            errors++;
            $display("FAIL pause cyc%0d tick=%b slow=%b want %b %b", i, tick, slow_clk, e_tick(), e_slow());
         end
      end
      ch_en = 2'b11;
      step();
      checks++;
      if (tick[0] !== 1'b0) begin
         errors++;
         $display("FAIL resume_early tick0=%b want 0", tick[0]);
      end
      step();
      checks++;
      if (tick[0] !== 1'b1 || slow_clk[0] === s0) begin
         errors++;
         $display("FAIL resume_tick tick0=%b slow0=%b want 1 %b", tick[0], slow_clk[0], ~s0);
      end
   endtask

   task automatic test_async_reset();
      int nt = 0;
      ch_en = 2'b01;
      for (int i = 0; i < 20 && !m_slow[0]; i++) step();
      cfg_ch = 1'b0; cfg_div = 8'd5; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      checks++;
      if (slow_clk !== e_slow() || cfg_ready !== e_rdy()) begin
         errors++;
         $display("FAIL arst_pre slow=%b rdy=%b want %b %b", slow_clk, cfg_ready, e_slow(), e_rdy());
      end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      m_reset();
      checks++;
      if (tick !== 2'b00 || slow_clk !== 2'b00 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL arst_now tick=%b slow=%b rdy=%b want 00 00 1", tick, slow_clk, cfg_ready);
      end
      @(negedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         nt += int'(tick[0]);
         checks++;
         if (tick !== e_tick() || slow_clk !== e_slow()) begin
            errors++;
            $display("FAIL arst_run cyc%0d tick=%b slow=%b want %b %b", i, tick, slow_clk, e_tick(), e_slow());
         end
      end
      checks++;
      if (nt != 3) begin
         errors++;
         $display("FAIL arst_default ticks=%0d want 3", nt);
      end
   endtask

   task automatic test_max_div();
      int nt = 0;
      ch_en = 2'b00; cfg_ch = 1'b0; cfg_div = 8'd255; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      ch_en = 2'b01;
      for (int i = 0; i < 600; i++) begin
         step();
         nt += int'(tick[0]);
         if (tick !== e_tick() || slow_clk !== e_slow()) begin
            checks++;
            errors++;
            $display("FAIL maxdiv cyc%0d tick=%b slow=%b want %b %b", i, tick, slow_clk, e_tick(), e_slow());
         end
      end
      checks++;
      if (nt != 2) begin
         errors++;
         $display("FAIL maxdiv_count ticks=%0d want 2", nt);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         ch_en = 2'($urandom);
         cfg_valid = ($urandom % 3) == 0;
         cfg_ch = 1'($urandom);
         cfg_div = 8'($urandom % 6);
         #1;
         checks++;
         if (cfg_ready !== e_rdy()) begin
            errors++;
            $display("FAIL rand_ready cyc%0d rdy=%b want %b", i, cfg_ready, e_rdy());
         end
         step();
         checks++;
         if (tick !== e_tick() || slow_clk !== e_slow()) begin
            errors++;
            $display("FAIL rand cyc%0d tick=%b slow=%b want %b %b", i, tick, slow_clk, e_tick(), e_slow());
         end
      end
      cfg_valid = 1'b0;
   endtask

`ifdef MULTI_TICK_SYNC_EN
   task automatic test_sync();
      ch_en = 2'b00; cfg_valid = 1'b1; cfg_div = 8'd3;
      cfg_ch = 1'b0; step();
      cfg_ch = 1'b1; step();
      cfg_valid = 1'b0;
      ch_en = 2'b01;
      repeat (2) step();
      ch_en = 2'b11;
      repeat (3) step();
      sync = 1'b1;
      #1;
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL sync_ready rdy=%b want 0", cfg_ready);
      end
      step();
      sync = 1'b0;
      checks++;
      if (tick !== 2'b00 || slow_clk !== 2'b00) begin
         errors++;
         $display("FAIL sync_clear tick=%b slow=%b want 00 00", tick, slow_clk);
      end
      for (int i = 0; i < 12; i++) begin
         step();
         checks++;
         if (tick[0] !== tick[1] || tick !== e_tick() || slow_clk !== e_slow()) begin
            errors++;
            $display("FAIL sync_align cyc%0d tick=%b slow=%b want %b %b", i, tick, slow_clk, e_tick(), e_slow());
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_reload();
      test_disabled_load();
      test_pause();
      test_async_reset();
      test_max_div();
      test_random();
`ifdef MULTI_TICK_SYNC_EN
      test_sync();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
